// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants and helpers for the MIPS fetch stage:
//               datapath width, opcode field position, noop opcode/word
//               and the default reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned OPC_MSB = 31;
  localparam int unsigned OPC_LSB = 26;

  localparam logic [5:0]      NOOP_OPCODE_DEF = 6'b111111;
  localparam logic [XLEN-1:0] NOP_WORD_DEF    = {NOOP_OPCODE_DEF, 26'b0};
  localparam logic [XLEN-1:0] RESET_PC_DEF    = 32'h0000_0000;

  // Extract the primary opcode field of an instruction word.
  function automatic logic [5:0] opcode_of(input logic [XLEN-1:0] word);
    return word[OPC_MSB:OPC_LSB];
  endfunction

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module      : instruction_fetch_if
// Description : Bus bundle of the fetch stage: instruction-memory port,
//               decode-side control inputs and the IF/ID register outputs.
//               master = fetch stage, slave = surrounding pipeline/memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if;
  import mips_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_data;
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;
  logic            if_valid;
  logic            halted;
  logic [XLEN-1:0] fetch_count;

  modport master (
    output imem_addr, if_instr, if_pc, if_pc_plus4, if_valid, halted, fetch_count,
    input  imem_data, stall, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, if_instr, if_pc, if_pc_plus4, if_valid, halted, fetch_count,
    output imem_data, stall, redirect_valid, redirect_pc
  );

endinterface

`default_nettype wire

// File: rtl/instruction_fetch_pc_register.sv
// ============================================================================
// Module      : pc_register
// Description : 32-bit program counter with async active-low reset and a
//               next-PC mux: redirect target (word aligned) / PC+4 / hold.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_register
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  input  wire logic            i_redirect,
  input  wire logic            i_advance,
  input  wire logic [XLEN-1:0] i_redirect_pc,
  output logic      [XLEN-1:0] o_pc
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;

  // Next-PC select: redirect wins, then sequential advance, else hold.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect) begin
      w_pc_next = i_redirect_pc & ~32'h0000_0003;
    end else if (i_advance) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  // PC state; reset is asynchronous so the fetch address snaps back at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : MIPS instruction-fetch stage. Owns the PC, drives the
//               combinational instruction ROM, captures its word into IF/ID,
//               and handles stall, redirect and halt-on-noop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC     = RESET_PC_DEF,
  parameter logic [5:0]      NOOP_OPCODE  = NOOP_OPCODE_DEF,
  parameter bit              HALT_ON_NOOP = 1'b1
) (
  input wire logic             clk,
  input wire logic             rst_n,
  instruction_fetch_if.master  bus
);

  localparam logic [XLEN-1:0] c_NOP_WORD = {NOOP_OPCODE, 26'b0};

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  logic [0:0]      r_state;
  logic [0:0]      w_state_next;
  logic [XLEN-1:0] w_pc;
  logic            w_noop;
  logic            w_pc_advance;
  logic            w_ifid_load;
  logic            w_ifid_bubble;
  logic            w_count_inc;

  logic [XLEN-1:0] r_if_instr;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pc_plus4;
  logic            r_if_valid;
  logic [XLEN-1:0] r_fetch_count;

  assign w_noop = (opcode_of(bus.imem_data) == NOOP_OPCODE);

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_redirect    (bus.redirect_valid),
    .i_advance     (w_pc_advance),
    .i_redirect_pc (bus.redirect_pc),
    .o_pc          (w_pc)
  );

  // Halt-state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Halt-state transitions: redirect always resumes, stall freezes.
  always_comb begin
    w_state_next = r_state;
    if (bus.redirect_valid) begin
      w_state_next = ST_RUN;
    end else if (!bus.stall && (r_state == ST_RUN) && w_noop && HALT_ON_NOOP) begin
      w_state_next = ST_HALT;
    end
  end

  // Per-cycle action decode in priority order redirect/stall/halt/noop/normal.
  always_comb begin
    w_pc_advance  = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_bubble = 1'b0;
    w_count_inc   = 1'b0;
    if (bus.redirect_valid) begin
      w_ifid_bubble = 1'b1;
    end else if (bus.stall) begin
      w_ifid_bubble = 1'b0;
    end else if (r_state == ST_HALT) begin
      w_ifid_bubble = 1'b1;
    end else if (w_noop) begin
      w_ifid_bubble = 1'b1;
      w_pc_advance  = !HALT_ON_NOOP;
    end else begin
      w_ifid_load   = 1'b1;
      w_pc_advance  = 1'b1;
      w_count_inc   = 1'b1;
    end
  end

  // IF/ID register; bubbles keep if_pc/if_pc_plus4 of the last real entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_instr    <= c_NOP_WORD;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
      r_if_valid    <= 1'b0;
    end else if (w_ifid_bubble) begin
      r_if_instr    <= c_NOP_WORD;
      r_if_valid    <= 1'b0;
    end else if (w_ifid_load) begin
      r_if_instr    <= bus.imem_data;
      r_if_pc       <= w_pc;
      r_if_pc_plus4 <= w_pc + 32'd4;
      r_if_valid    <= 1'b1;
    end
  end

  // Delivered-instruction counter, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
    end else if (w_count_inc && (r_fetch_count != '1)) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign bus.imem_addr   = w_pc;
  assign bus.if_instr    = r_if_instr;
  assign bus.if_pc       = r_if_pc;
  assign bus.if_pc_plus4 = r_if_pc_plus4;
  assign bus.if_valid    = r_if_valid;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.fetch_count = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch with a
//               small behavioural instruction ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

  localparam logic [31:0] W0   = 32'h2010_0007; // addi r16,r0,7
  localparam logic [31:0] W1   = 32'hAC10_0000; // sw   r16,0(r0)
  localparam logic [31:0] W2   = 32'h8C11_0000; // lw   r17,0(r0)
  localparam logic [31:0] W3   = 32'h0211_9020; // add  r18,r16,r17
  localparam logic [31:0] WTOP = 32'h2011_0001; // addi r17,r0,1 at 0xFFFFFFFC
  localparam logic [31:0] NOP  = 32'hFC00_0000;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC     (32'h0000_0000),
    .NOOP_OPCODE  (6'b111111),
    .HALT_ON_NOOP (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural combinational ROM: unmapped addresses return the noop word.
  always_comb begin
    case (bus.imem_addr)
      32'h0000_0000: bus.imem_data = W0;
      32'h0000_0004: bus.imem_data = W1;
      32'h0000_0008: bus.imem_data = W2;
      32'h0000_000C: bus.imem_data = W3;
      32'hFFFF_FFFC: bus.imem_data = WTOP;
      default:       bus.imem_data = NOP;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_addr"},  bus.imem_addr,   32'h0);
    chk({tag, "_valid"}, {31'b0, bus.if_valid}, 32'h0);
    chk({tag, "_instr"}, bus.if_instr,    NOP);
    chk({tag, "_pc"},    bus.if_pc,       32'h0);
    chk({tag, "_pc4"},   bus.if_pc_plus4, 32'h0);
    chk({tag, "_halt"},  {31'b0, bus.halted}, 32'h0);
    chk({tag, "_cnt"},   bus.fetch_count, 32'h0);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] instr,
                          input logic [31:0] pc, input logic valid);
    chk({tag, "_instr"}, bus.if_instr,    instr);
    chk({tag, "_pc"},    bus.if_pc,       pc);
    chk({tag, "_pc4"},   bus.if_pc_plus4, pc + 32'd4);
    chk({tag, "_valid"}, {31'b0, bus.if_valid}, {31'b0, valid});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n              = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    #1 rst_n = 1'b0;
    #2;
    chk_reset_values("rst");
    step();
    step();
    rst_n = 1'b1;

    // Straight-line program.
    step(); chk_ifid("f0", W0, 32'h0, 1'b1); chk("f0_addr", bus.imem_addr, 32'h4);
    step(); chk_ifid("f1", W1, 32'h4, 1'b1);
    step(); chk_ifid("f2", W2, 32'h8, 1'b1);
    step(); chk_ifid("f3", W3, 32'hC, 1'b1);
    chk("f3_addr", bus.imem_addr, 32'h10);
    chk("f3_cnt", bus.fetch_count, 32'd4);

    // Noop at 0x10 halts fetch.
    step();
    chk("halt_flag", {31'b0, bus.halted}, 32'h1);
    chk("halt_addr", bus.imem_addr, 32'h10);
    chk("halt_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("halt_instr", bus.if_instr, NOP);
    chk("halt_cnt", bus.fetch_count, 32'd4);
    step();
    chk("halt_hold_addr", bus.imem_addr, 32'h10);
    chk("halt_hold_flag", {31'b0, bus.halted}, 32'h1);

    // Redirect to misaligned 0x6 while stalled and halted.
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h6;
    step();
    chk("rd_addr", bus.imem_addr, 32'h4);
    chk("rd_halt", {31'b0, bus.halted}, 32'h0);
    chk("rd_valid", {31'b0, bus.if_valid}, 32'h0);
    chk("rd_instr", bus.if_instr, NOP);
    chk("rd_pc_hold", bus.if_pc, 32'hC);
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    chk_ifid("rd_tgt", W1, 32'h4, 1'b1);
    chk("rd_tgt_cnt", bus.fetch_count, 32'd5);

    // Stall three cycles with PC=0x8.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_addr", bus.imem_addr, 32'h8);
      chk("st_pc", bus.if_pc, 32'h4);
      chk("st_instr", bus.if_instr, W1);
      chk("st_cnt", bus.fetch_count, 32'd5);
    end
    bus.stall = 1'b0;
    step();
    chk_ifid("st_rel", W2, 32'h8, 1'b1);
    chk("st_rel_cnt", bus.fetch_count, 32'd6);

    // Wrap at top of address space.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    chk("wr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid", {31'b0, bus.if_valid}, 32'h0);
    bus.redirect_valid = 1'b0;
    step();
    chk("wr_instr", bus.if_instr, WTOP);
    chk("wr_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", bus.if_pc_plus4, 32'h0);
    chk("wr_addr0", bus.imem_addr, 32'h0);
    chk("wr_cnt", bus.fetch_count, 32'd7);

    // Clean restart, fetch three, then async reset mid-stream.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("mr_addr", bus.imem_addr, 32'hC);
    chk("mr_cnt", bus.fetch_count, 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_values("arst");
    step();
    rst_n = 1'b1;
    step();
    chk_ifid("refetch", W0, 32'h0, 1'b1);
    chk("refetch_cnt", bus.fetch_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
